// File: rtl/pipe_sched_pkg.sv
// Shared definitions for the round-robin pipe scheduler.
//   sched_state_t : scheduler FSM states (RUN, DRAIN, DRAINED)
//   tag_width()   : bits needed to carry a requester index
//   entry_width() : bits in one pipe entry {tag, data}
package pipe_sched_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_DRAINED = 2'd2
    } sched_state_t;

    function automatic int tag_width(input int n_req);
        return (n_req > 1) ? $clog2(n_req) : 1;
    endfunction

    function automatic int entry_width(input int n_req, input int width);
        return tag_width(n_req) + width;
    endfunction

endpackage

// File: rtl/tagged_valid_pipe.sv
// Fixed-latency, never-stalling pipe of depth stages carrying {valid, tag, data}.
//   clk, rst               : clock, asynchronous active-low reset
//   i_vld, i_tag, i_data   : entry loaded into stage 0 each rising edge
//   o_vld, o_tag, o_data   : contents of the last stage (retiring entry)
module tagged_valid_pipe
    import pipe_sched_pkg::*;
#(
    parameter int width = 8,
    parameter int tag_w = tag_width(4),
    parameter int depth = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_vld,
    input  logic [tag_w-1:0]  i_tag,
    input  logic [width-1:0]  i_data,
    output logic              o_vld,
    output logic [tag_w-1:0]  o_tag,
    output logic [width-1:0]  o_data
);

    logic [depth-1:0]             r_vld;
    logic [depth-1:0][tag_w-1:0]  r_tag;
    logic [depth-1:0][width-1:0]  r_data;

    // Reset clears payload as well so a discarded entry can never leak out.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_vld  <= '0;
            r_tag  <= '0;
            r_data <= '0;
        end else begin
            r_vld[0]  <= i_vld;
            r_tag[0]  <= i_tag;
            r_data[0] <= i_data;
            for (int s = 1; s < depth; s++) begin
                r_vld[s]  <= r_vld[s-1];
                r_tag[s]  <= r_tag[s-1];
                r_data[s] <= r_data[s-1];
            end
        end
    end

    assign o_vld  = r_vld[depth-1];
    assign o_tag  = r_tag[depth-1];
    assign o_data = r_data[depth-1];

endmodule

// File: rtl/pipe_rr_scheduler.sv
// Round-robin arbiter feeding a fixed-latency pipe, with drain control.
//   clk, rst    : clock, asynchronous active-low reset
//   req_vld     : per-requester request valid
//   req_data    : per-requester payload
//   req_rdy     : one-hot-or-zero grant (transfer when vld & rdy)
//   drain       : level request to stop issuing and empty the pipe
//   drained     : high while in DRAINED
//   out_vld     : one-hot-or-zero result valid, indexed by entry tag
//   out_data    : retiring payload, or last retired payload when idle
//   in_flight   : number of valid entries in the pipe
module pipe_rr_scheduler
    import pipe_sched_pkg::*;
#(
    parameter int width = 8,
    parameter int depth = 4,
    parameter int n_req = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [n_req-1:0]               req_vld,
    input  logic [n_req-1:0][width-1:0]    req_data,
    output logic [n_req-1:0]               req_rdy,
    input  logic                           drain,
    output logic                           drained,
    output logic [n_req-1:0]               out_vld,
    output logic [width-1:0]               out_data,
    output logic [$clog2(depth+1)-1:0]     in_flight
);

    localparam int TW = tag_width(n_req);
    localparam int CW = $clog2(depth + 1);

    sched_state_t     r_state;
    logic [TW-1:0]    r_rr_ptr;
    logic [CW-1:0]    r_in_flight;
    logic [width-1:0] r_last_data;

    logic [n_req-1:0] w_gnt_oh;
    logic [TW-1:0]    w_gnt_idx;
    logic             w_xfer;
    logic             w_ret_vld;
    logic [TW-1:0]    w_ret_tag;
    logic [width-1:0] w_ret_data;

    // Arbiter: first valid requester at or after rr_ptr, wrapping. Gated by
    // rst so no grant is visible while reset is held.
    always_comb begin
        int unsigned idx;
        idx       = 0;
        w_gnt_oh  = '0;
        w_gnt_idx = '0;
        w_xfer    = 1'b0;
        if (rst && (r_state == ST_RUN) && !drain) begin
            for (int k = 0; k < n_req; k++) begin
                idx = (int'(r_rr_ptr) + k) % n_req;
                if (!w_xfer && req_vld[idx]) begin
                    w_xfer        = 1'b1;
                    w_gnt_idx     = TW'(idx);
                    w_gnt_oh[idx] = 1'b1;
                end
            end
        end
    end

    assign req_rdy = w_gnt_oh;

    tagged_valid_pipe #(
        .width (width),
        .tag_w (TW),
        .depth (depth)
    ) u_pipe (
        .clk    (clk),
        .rst    (rst),
        .i_vld  (w_xfer),
        .i_tag  (w_gnt_idx),
        .i_data (req_data[w_gnt_idx]),
        .o_vld  (w_ret_vld),
        .o_tag  (w_ret_tag),
        .o_data (w_ret_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rr_ptr <= '0;
        end else if (w_xfer) begin
            r_rr_ptr <= (w_gnt_idx == TW'(n_req - 1)) ? '0 : w_gnt_idx + TW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_RUN;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (drain) r_state <= (r_in_flight != '0) ? ST_DRAIN : ST_DRAINED;
                end
                ST_DRAIN: begin
                    if (!drain)                   r_state <= ST_RUN;
                    else if (r_in_flight == '0)   r_state <= ST_DRAINED;
                end
                ST_DRAINED: begin
                    if (!drain) r_state <= ST_RUN;
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

    // Simultaneous issue and retire leave the count unchanged.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_in_flight <= '0;
        end else begin
            case ({w_xfer, w_ret_vld})
                2'b10:   r_in_flight <= r_in_flight + CW'(1);
                2'b01:   r_in_flight <= r_in_flight - CW'(1);
                default: r_in_flight <= r_in_flight;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last_data <= '0;
        end else if (w_ret_vld) begin
            r_last_data <= w_ret_data;
        end
    end

    always_comb begin
        out_vld = '0;
        if (w_ret_vld) out_vld[w_ret_tag] = 1'b1;
    end

    assign out_data  = w_ret_vld ? w_ret_data : r_last_data;
    assign drained   = (r_state == ST_DRAINED);
    assign in_flight = r_in_flight;

endmodule

// File: tb/tb_pipe_rr_scheduler.sv
module tb_pipe_rr_scheduler;

    localparam int W = 8;
    localparam int D = 4;
    localparam int N = 4;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                drain = 1'b0;
    logic                drained;
    logic [N-1:0]        req_vld = '0;
    logic [N-1:0]        req_rdy;
    logic [N-1:0]        out_vld;
    logic [N-1:0][W-1:0] req_data = '0;
    logic [W-1:0]        out_data;
    logic [2:0]          in_flight;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipe_rr_scheduler #(
        .width (W),
        .depth (D),
        .n_req (N)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_vld   (req_vld),
        .req_data  (req_data),
        .req_rdy   (req_rdy),
        .drain     (drain),
        .drained   (drained),
        .out_vld   (out_vld),
        .out_data  (out_data),
        .in_flight (in_flight)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Payload for issue i from requester r: high nibble i, low nibble r.
    task automatic set_data(input int i);
        for (int r = 0; r < N; r++) req_data[r] = 8'(((i % 16) * 16) + r);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        req_vld = 4'hF;
        repeat (3) step();
        checks++; if (req_rdy !== 4'b0000) begin failures++; $display("FAIL reset_rdy got=%b exp=%b", req_rdy, 4'b0000); end
        checks++; if (out_vld !== 4'b0000) begin failures++; $display("FAIL reset_out_vld got=%b exp=%b", out_vld, 4'b0000); end
        checks++; if (out_data !== 8'h00) begin failures++; $display("FAIL reset_out_data got=%h exp=%h", out_data, 8'h00); end
        checks++; if (drained !== 1'b0) begin failures++; $display("FAIL reset_drained got=%b exp=%b", drained, 1'b0); end
        checks++; if (in_flight !== 3'd0) begin failures++; $display("FAIL reset_in_flight got=%0d exp=%0d", in_flight, 0); end
        req_vld = '0;
        #2 rst = 1'b1;
    endtask

    task automatic test_single();
        req_data = {8'hFF, 8'h5A, 8'hFF, 8'hFF};
        req_vld = 4'b0100;
        #1;
        checks++; if (req_rdy !== 4'b0100) begin failures++; $display("FAIL single_rdy got=%b exp=%b", req_rdy, 4'b0100); end
        step();
        req_vld = '0;
        checks++; if (in_flight !== 3'd1) begin failures++; $display("FAIL single_in_flight got=%0d exp=%0d", in_flight, 1); end
        checks++; if (out_vld !== 4'b0000) begin failures++; $display("FAIL single_early0 got=%b exp=%b", out_vld, 4'b0000); end
        for (int k = 1; k <= 4; k++) begin
            step();
            if (k == 3) begin
                checks++; if (out_vld !== 4'b0100) begin failures++; $display("FAIL single_out_vld k=%0d got=%b exp=%b", k, out_vld, 4'b0100); end
                checks++; if (out_data !== 8'h5A) begin failures++; $display("FAIL single_out_data got=%h exp=%h", out_data, 8'h5A); end
            end else begin
                checks++; if (out_vld !== 4'b0000) begin failures++; $display("FAIL single_idle k=%0d got=%b exp=%b", k, out_vld, 4'b0000); end
            end
        end
        checks++; if (out_data !== 8'h5A) begin failures++; $display("FAIL single_hold got=%h exp=%h", out_data, 8'h5A); end
        checks++; if (in_flight !== 3'd0) begin failures++; $display("FAIL single_empty got=%0d exp=%0d", in_flight, 0); end
    endtask

    // rr_ptr should now be 3: with requesters 0 and 3 valid, 3 wins.
    task automatic test_rr_ptr();
        req_data = {8'hC3, 8'h00, 8'h00, 8'h11};
        req_vld = 4'b1001;
        #1;
        checks++; if (req_rdy !== 4'b1000) begin failures++; $display("FAIL rrptr_rdy got=%b exp=%b", req_rdy, 4'b1000); end
        step();
        req_vld = '0;
        for (int k = 1; k <= 4; k++) begin
            step();
            if (k == 3) begin
                checks++; if (out_vld !== 4'b1000 || out_data !== 8'hC3) begin failures++; $display("FAIL rrptr_out got=%b/%h exp=%b/%h", out_vld, out_data, 4'b1000, 8'hC3); end
            end
        end
    endtask

    task automatic test_stream(input int n, input string nm);
        logic [N-1:0] exp_o;
        logic [W-1:0] exp_d;
        set_data(0);
        req_vld = '1;
        #1;
        checks++; if (req_rdy !== 4'b0001) begin failures++; $display("FAIL %s_rdy0 got=%b exp=%b", nm, req_rdy, 4'b0001); end
        for (int j = 0; j < n + 4; j++) begin
            step();
            exp_o = (j >= 3 && j - 3 < n) ? 4'(1 << ((j - 3) % 4)) : 4'b0000;
            checks++; if (out_vld !== exp_o) begin failures++; $display("FAIL %s_out_vld j=%0d got=%b exp=%b", nm, j, out_vld, exp_o); end
            if (exp_o != 4'b0000) begin
                exp_d = 8'((((j - 3) % 16) * 16) + ((j - 3) % 4));
                checks++; if (out_data !== exp_d) begin failures++; $display("FAIL %s_out_data j=%0d got=%h exp=%h", nm, j, out_data, exp_d); end
            end
            if (j >= 3 && j < n) begin
                checks++; if (in_flight !== 3'd4) begin failures++; $display("FAIL %s_in_flight j=%0d got=%0d exp=%0d", nm, j, in_flight, 4); end
            end
            if (j + 1 < n) begin
                set_data(j + 1);
                #1;
                checks++; if (req_rdy !== 4'(1 << ((j + 1) % 4))) begin failures++; $display("FAIL %s_rdy j=%0d got=%b exp=%b", nm, j + 1, req_rdy, 4'(1 << ((j + 1) % 4))); end
            end else begin
                req_vld = '0;
            end
        end
        checks++; if (in_flight !== 3'd0) begin failures++; $display("FAIL %s_final_in_flight got=%0d exp=%0d", nm, in_flight, 0); end
    endtask

    task automatic test_drain();
        int cyc;
        int cnt;
        cyc = 0;
        cnt = 0;
        req_data = '0;
        req_vld = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            req_data[0] = 8'(8'hA0 + k);
            step();
        end
        checks++; if (in_flight !== 3'd3) begin failures++; $display("FAIL drain_in_flight3 got=%0d exp=%0d", in_flight, 3); end
        req_vld = '1;
        drain = 1'b1;
        #1;
        checks++; if (req_rdy !== 4'b0000) begin failures++; $display("FAIL drain_rdy_now got=%b exp=%b", req_rdy, 4'b0000); end
        while (!drained && cyc < 20) begin
            step();
            cyc++;
            if (out_vld !== 4'b0000) begin
                checks++; if (out_vld !== 4'b0001 || out_data !== 8'(8'hA0 + cnt)) begin failures++; $display("FAIL drain_retire n=%0d got=%b/%h exp=%b/%h", cnt, out_vld, out_data, 4'b0001, 8'(8'hA0 + cnt)); end
                cnt++;
            end
            checks++; if (req_rdy !== 4'b0000) begin failures++; $display("FAIL drain_rdy c=%0d got=%b exp=%b", cyc, req_rdy, 4'b0000); end
        end
        checks++; if (drained !== 1'b1) begin failures++; $display("FAIL drain_drained got=%b exp=%b", drained, 1'b1); end
        checks++; if (cnt != 3) begin failures++; $display("FAIL drain_retire_count got=%0d exp=%0d", cnt, 3); end
        checks++; if (in_flight !== 3'd0) begin failures++; $display("FAIL drain_in_flight0 got=%0d exp=%0d", in_flight, 0); end
        drain = 1'b0;
        #1;
        checks++; if (req_rdy !== 4'b0000) begin failures++; $display("FAIL drain_still_drained got=%b exp=%b", req_rdy, 4'b0000); end
        step();
        checks++; if (drained !== 1'b0) begin failures++; $display("FAIL drain_run drained got=%b exp=%b", drained, 1'b0); end
        checks++; if (req_rdy !== 4'b0010) begin failures++; $display("FAIL drain_resume got=%b exp=%b", req_rdy, 4'b0010); end
        step();
        req_vld = '0;
        checks++; if (in_flight !== 3'd1) begin failures++; $display("FAIL drain_resume_issue got=%0d exp=%0d", in_flight, 1); end
        repeat (5) step();
    endtask

    task automatic test_reset_mid();
        set_data(7);
        req_vld = '1;
        repeat (5) step();
        checks++; if (in_flight !== 3'd4) begin failures++; $display("FAIL rmid_pre got=%0d exp=%0d", in_flight, 4); end
        #3 rst = 1'b0;
        #1;
        checks++; if (out_vld !== 4'b0000) begin failures++; $display("FAIL rmid_out_vld got=%b exp=%b", out_vld, 4'b0000); end
        checks++; if (out_data !== 8'h00) begin failures++; $display("FAIL rmid_out_data got=%h exp=%h", out_data, 8'h00); end
        checks++; if (req_rdy !== 4'b0000) begin failures++; $display("FAIL rmid_rdy got=%b exp=%b", req_rdy, 4'b0000); end
        checks++; if (in_flight !== 3'd0) begin failures++; $display("FAIL rmid_in_flight got=%0d exp=%0d", in_flight, 0); end
        repeat (2) step();
        req_data = '0;
        req_data[0] = 8'h3C;
        req_vld = 4'b0001;
        #2 rst = 1'b1;
        #1;
        checks++; if (req_rdy !== 4'b0001) begin failures++; $display("FAIL rmid_first_rdy got=%b exp=%b", req_rdy, 4'b0001); end
        step();
        req_vld = '0;
        checks++; if (in_flight !== 3'd1) begin failures++; $display("FAIL rmid_first_issue got=%0d exp=%0d", in_flight, 1); end
        for (int k = 1; k <= 5; k++) begin
            step();
            if (k == 3) begin
                checks++; if (out_vld !== 4'b0001 || out_data !== 8'h3C) begin failures++; $display("FAIL rmid_new_out got=%b/%h exp=%b/%h", out_vld, out_data, 4'b0001, 8'h3C); end
            end else begin
                checks++; if (out_vld !== 4'b0000) begin failures++; $display("FAIL rmid_stale k=%0d got=%b exp=%b", k, out_vld, 4'b0000); end
            end
            if (k == 1) begin
                checks++; if (out_data !== 8'h00) begin failures++; $display("FAIL rmid_data_cleared got=%h exp=%h", out_data, 8'h00); end
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_rr_ptr();
        test_stream(8, "rr8");
        test_stream(24, "steady");
        test_drain();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_rr_scheduler.md
PIPE_RR_SCHEDULER -- requirements
Module: pipe_rr_scheduler

Interface
REQ-001 SHALL have parameter: width, 8, data width per request.
REQ-002 SHALL have parameter: depth, 4, fixed pipeline latency in cycles (>= 2).
REQ-003 SHALL have parameter: n_req, 4, requester count (2..8).
REQ-004 SHALL have port: clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port: rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port: req_vld  input  n_req  per-requester request valid.
REQ-007 SHALL have port: req_data  input  n_req x width  per-requester payload.
REQ-008 SHALL have port: req_rdy  output  n_req  one-hot-or-zero grant; a transfer occurs when req_vld[i] and req_rdy[i] are both high.
REQ-009 SHALL have port: drain  input  1  level request to stop issuing and empty the pipe.
REQ-010 SHALL have port: drained  output  1  high while in DRAINED state.
REQ-011 SHALL have port: out_vld  output  n_req  per-requester result valid, one-hot-or-zero.
REQ-012 SHALL have port: out_data  output  width  payload of the retiring entry.
REQ-013 SHALL have port: in_flight  output  clog2(depth+1)  number of valid entries in the pipe.

Function
REQ-014 SHALL implement FSM states RUN, DRAIN, DRAINED.
REQ-015 SHALL transition RUN->DRAIN when drain=1 and in_flight!=0, and RUN->DRAINED when drain=1 and in_flight=0.
REQ-016 SHALL transition DRAIN->DRAINED when in_flight=0, and DRAINED->RUN when drain=0; drain deasserted while in DRAIN returns to RUN.
REQ-017 SHALL grant only in RUN with drain=0; req_rdy SHALL be all-zero otherwise.
REQ-018 SHALL grant, in RUN, the first requester with req_vld=1 searching from rr_ptr upward modulo n_req; req_rdy SHALL be combinational from req_vld, rr_ptr and state.
REQ-019 SHALL advance rr_ptr to (granted index + 1) mod n_req on each transfer and hold it otherwise.
REQ-020 SHALL issue one entry per transfer into stage 0, carrying {tag = granted index, req_data}; no transfer SHALL inject a bubble (valid=0).
REQ-021 SHALL present the entry issued at rising edge t on out_vld[tag]/out_data in the cycle after rising edge t+depth-1, i.e. exactly depth cycles after issue; the pipe never stalls.
REQ-022 SHALL drive out_data as the retiring payload when any out_vld is set, and hold the last retired payload otherwise.
REQ-023 SHALL update in_flight as +1 on issue, -1 on retire, unchanged on simultaneous issue and retire; it SHALL never exceed depth.
REQ-024 SHALL ignore req_data of non-granted requesters; a requester held valid without a grant SHALL be served within n_req transfers.

Reset
REQ-025 SHALL, while rst=0, asynchronously force state=RUN, rr_ptr=0, all pipe valids=0, pipe data and tags=0, in_flight=0.
REQ-026 SHALL hold req_rdy=0, out_vld=0, out_data=0 and drained=0 during reset; entries in flight at reset assertion SHALL be discarded, never emitted.
REQ-027 SHALL allow the first grant on the first rising edge after rst deasserts.

Structure
REQ-028 SHALL place in a shared package pipe_sched_pkg the state enum (RUN, DRAIN, DRAINED) and the entry struct {tag, data} width helpers.
REQ-029 SHALL use one sub-module, tagged_valid_pipe, as the depth-stage valid-qualified pipe with asynchronous active-low reset, carrying tag and data.
REQ-030 SHALL keep the arbiter, rr_ptr, FSM, in_flight counter and output demux in pipe_rr_scheduler.

Verification (width=8, depth=4, n_req=4)
REQ-031 SHALL cover: req 2 alone, data 0x5A at edge 10 -> out_vld=4'b0100, out_data=0x5A in cycle after edge 13; rr_ptr=3.
REQ-032 SHALL cover: all four valid for 8 cycles from rr_ptr=0 -> grants 0,1,2,3,0,1,2,3; outputs in the same order, 4 cycles later, back-to-back.
REQ-033 SHALL cover: in_flight=3, drain=1 -> req_rdy=0 immediately, DRAIN for 3 retires, drained=1 once in_flight=0; drain=0 -> RUN and grants resume next cycle.
REQ-034 SHALL cover: rst=0 mid-stream with in_flight=4 -> all outputs 0 asynchronously, no stale out_vld after release, in_flight=0.
REQ-035 SHALL cover: simultaneous issue and retire each cycle for 20 cycles -> in_flight constant at 4; scoreboard matches every tag/data.
